// File: rtl/regfile_sb.sv
// Register file: 2 combinational read ports, 1 synchronous write port, DEPTH-cycle clear sequencer, RAW scoreboard.
// No backpressure: init_busy asks the core to stall during clear; `REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] regData1,
    output logic [DATA_W-1:0] regData2,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reserveReg,
    output logic              busy1,
    output logic              busy2,
    output logic              init_busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic ready;
    logic wr_zero;
    logic res_zero;
    logic rd1_zero;
    logic rd2_zero;
    logic byp1;
    logic byp2;

    assign ready    = (state_q == READY);
    assign wr_zero  = (ZERO_REG != 0) && (writeReg == '0);
    assign res_zero = (ZERO_REG != 0) && (reserveReg == '0);
    assign rd1_zero = (ZERO_REG != 0) && (readReg1 == '0);
    assign rd2_zero = (ZERO_REG != 0) && (readReg2 == '0);

    // Clear sequencer owns the write port until the last entry is zeroed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = writeReg;
        mem_wdata = writeData;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (&cnt_q) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                mem_we = regWrite && !wr_zero;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // A reservation is applied after the write-clear so a new producer wins.
    always_comb begin
        pend_d = pend_q;
        if (ready) begin
            if (regWrite) begin
                pend_d[writeReg] = 1'b0;
            end
            if (reserve && !res_zero) begin
                pend_d[reserveReg] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Storage has no reset; the clear sequencer defines its contents.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = ready && regWrite && (writeReg == readReg1) && !rd1_zero;
    assign byp2 = ready && regWrite && (writeReg == readReg2) && !rd2_zero;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        regData1 = '0;
        regData2 = '0;
        if (ready && !rd1_zero) begin
            regData1 = byp1 ? writeData : mem_q[readReg1];
        end
        if (ready && !rd2_zero) begin
            regData2 = byp2 ? writeData : mem_q[readReg2];
        end
    end

    assign busy1     = ready && !rd1_zero && !byp1 && pend_q[readReg1];
    assign busy2     = ready && !rd2_zero && !byp2 && pend_q[readReg2];
    assign init_busy = !ready;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb with a behavioural array model plus directed literal checks.
module tb_regfile_sb;
    logic        clk;
    logic        rst;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  readReg1, readReg2;
    logic [31:0] regData1, regData2;
    logic        reserve;
    logic [4:0]  reserveReg;
    logic        busy1, busy2, init_busy;

    logic        b_regWrite;
    logic [2:0]  b_writeReg;
    logic [15:0] b_writeData;
    logic [2:0]  b_readReg1, b_readReg2;
    logic [15:0] b_regData1, b_regData2;
    logic        b_reserve;
    logic [2:0]  b_reserveReg;
    logic        b_busy1, b_busy2, b_init_busy;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    regfile_sb dut (
        .clk(clk), .rst(rst), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .readReg1(readReg1), .readReg2(readReg2), .regData1(regData1), .regData2(regData2),
        .reserve(reserve), .reserveReg(reserveReg), .busy1(busy1), .busy2(busy2),
        .init_busy(init_busy)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .regWrite(b_regWrite), .writeReg(b_writeReg),
        .writeData(b_writeData), .readReg1(b_readReg1), .readReg2(b_readReg2),
        .regData1(b_regData1), .regData2(b_regData2), .reserve(b_reserve),
        .reserveReg(b_reserveReg), .busy1(b_busy1), .busy2(b_busy2), .init_busy(b_init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ready after 32 clean edges, then a plain array plus pending flags.
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    int          m_clr   = 0;
    bit          m_ready = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 0;
            m_clr   = 0;
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
        end else if (!m_ready) begin
            m_clr++;
            if (m_clr == 32) begin
                m_ready = 1;
                for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
            end
        end else begin
            if (regWrite) begin
                if (writeReg != 0) m_mem[writeReg] = writeData;
                m_pend[writeReg] = 0;
            end
            if (reserve && reserveReg != 0) m_pend[reserveReg] = 1;
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (!m_ready || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (regWrite && writeReg == a) return writeData;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!m_ready || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (regWrite && writeReg == a) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("regData1", regData1, exp_data(readReg1));
            check("regData2", regData2, exp_data(readReg2));
            check("busy1", {31'h0, busy1}, {31'h0, exp_busy(readReg1)});
            check("busy2", {31'h0, busy2}, {31'h0, exp_busy(readReg2)});
            check("init_busy", {31'h0, init_busy}, {31'h0, !m_ready});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        regWrite = 0; writeReg = 0; writeData = 0; reserve = 0; reserveReg = 0;
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        int n;
        int n2;
        rst = 1;
        idle_inputs();
        readReg1 = 0; readReg2 = 0;
        b_regWrite = 0; b_writeReg = 0; b_writeData = 0;
        b_readReg1 = 0; b_readReg2 = 0; b_reserve = 0; b_reserveReg = 0;
        cmp_en = 1;
        tick();
        tick();
        readReg1 = 5; readReg2 = 31;
        #1;
        check("rst_init_busy", {31'h0, init_busy}, 32'h1);
        check("rst_regData1", regData1, 32'h0);
        check("rst_busy2", {31'h0, busy2}, 32'h0);
        check("rst_b_init_busy", {31'h0, b_init_busy}, 32'h1);

        // Clear length on both instances.
        rst = 0;
        n = 100; n2 = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (!b_init_busy && n2 == 0) n2 = i;
            if (!init_busy) begin
                n = i;
                break;
            end
        end
        check("clear_edges_32", n, 32);
        check("clear_edges_8", n2, 8);

        for (int r = 0; r < 32; r++) begin
            readReg1 = 5'(r); readReg2 = 5'(31 - r);
            #1;
            check("cleared_rd1", regData1, 32'h0);
            check("cleared_rd2", regData2, 32'h0);
            tick();
        end

        // Basic write and read on both ports.
        regWrite = 1; writeReg = 5; writeData = 32'hDEADBEEF;
        readReg1 = 5; readReg2 = 5;
        tick();
        regWrite = 0;
        #1;
        check("r5_port1", regData1, 32'hDEADBEEF);
        check("r5_port2", regData2, 32'hDEADBEEF);

        regWrite = 1; writeReg = 0; writeData = 32'h12345678; readReg1 = 0;
        tick();
        regWrite = 0;
        #1;
        check("r0_stays_zero", regData1, 32'h0);

        // Reserve, then clearing write two cycles later.
        reserve = 1; reserveReg = 7; readReg1 = 7;
        tick();
        reserve = 0;
        #1;
        check("r7_busy_c1", {31'h0, busy1}, 32'h1);
        tick();
        check("r7_busy_c2", {31'h0, busy1}, 32'h1);
        regWrite = 1; writeReg = 7; writeData = 32'hA5A5A5A5;
        tick();
        regWrite = 0;
        #1;
        check("r7_busy_cleared", {31'h0, busy1}, 32'h0);
        check("r7_data", regData1, 32'hA5A5A5A5);

        reserve = 1; reserveReg = 7; regWrite = 1; writeReg = 7; writeData = 32'h1;
        tick();
        reserve = 0; regWrite = 0;
        #1;
        check("r7_same_edge_busy", {31'h0, busy1}, 32'h1);
        regWrite = 1; writeReg = 7; writeData = 32'h2;
        tick();
        regWrite = 0;
        #1;
        check("r7_release", {31'h0, busy1}, 32'h0);

        // Same-cycle write to the register being read.
        reserve = 1; reserveReg = 9; regWrite = 1; writeReg = 9; writeData = 32'h11;
        tick();
        reserve = 0;
        readReg1 = 9; writeData = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_data", regData1, 32'h55);
        check("byp_busy", {31'h0, busy1}, 32'h0);
`else
        check("nobyp_data", regData1, 32'h11);
        check("nobyp_busy", {31'h0, busy1}, 32'h1);
`endif
        tick();
        regWrite = 0;
        #1;
        check("r9_after_edge", regData1, 32'h55);
        check("r9_busy_after", {31'h0, busy1}, 32'h0);

        // Small instance without a hardwired zero register.
        b_regWrite = 1; b_writeReg = 0; b_writeData = 16'hBEEF; b_readReg1 = 0; b_readReg2 = 0;
        tick();
        b_regWrite = 0; b_reserve = 1; b_reserveReg = 0;
        #1;
        check("b_r0_data", {16'h0, b_regData1}, 32'h0000BEEF);
        tick();
        b_reserve = 0;
        #1;
        check("b_r0_busy", {31'h0, b_busy2}, 32'h1);

        // Reset during clear with traffic that must be ignored.
        rst = 1;
        tick();
        rst = 0;
        regWrite = 1; writeReg = 3; writeData = 32'hFFFFFFFF;
        reserve = 1; reserveReg = 3; readReg1 = 3;
        repeat (10) tick();
        check("midclr_init_busy", {31'h0, init_busy}, 32'h1);
        check("midclr_data", regData1, 32'h0);
        rst = 1;
        tick();
        check("midclr_rst_busy", {31'h0, init_busy}, 32'h1);
        rst = 0;
        n = 100;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (!init_busy) begin
                n = i;
                break;
            end
        end
        regWrite = 0; reserve = 0;
        #1;
        check("reclear_edges", n, 32);
        check("reclear_r3_data", regData1, 32'h0);
        check("reclear_r3_busy", {31'h0, busy1}, 32'h0);
        tick();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            regWrite   = ($urandom_range(0, 2) != 0);
            writeReg   = pick_addr();
            writeData  = $urandom;
            reserve    = ($urandom_range(0, 2) == 0);
            reserveReg = pick_addr();
            readReg1   = ($urandom_range(0, 3) == 0) ? writeReg : pick_addr();
            readReg2   = ($urandom_range(0, 3) == 0) ? reserveReg : pick_addr();
            rst        = ($urandom_range(0, 1499) == 0);
            tick();
        end
        rst = 0;
        idle_inputs();
        tick();
        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
